// File: rtl/shift_seq_unit_if.sv
// rtl/shift_seq_unit_if.sv - handshake/data bundle for the sequential shifter
//
// Purpose: groups the request, operand and result signals of shift_seq_unit.
// Ports (as seen by the shifter through modport slave):
//   start          in   request, taken only when the shifter is not busy
//   mode           in   00 lsl, 01 lsr, 10 asr, 11 ror (or lsr when rotate is absent)
//   amount         in   number of single-bit steps
//   D              in   operand captured on an accepted start
//   shift_in_right in   fill bit entering the LSB on logical left
//   shift_in_left  in   fill bit entering the MSB on logical right
//   S              out  working/result register
//   bb_out         out  bit shifted out on the most recent step
//   busy           out  high while steps remain
//   done           out  one-cycle pulse when S and bb_out are final
// The master modport is the controller's view of the same signals.
interface shift_seq_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] D;
  logic             shift_in_right;
  logic             shift_in_left;
  logic [WIDTH-1:0] S;
  logic             bb_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, D, shift_in_right, shift_in_left,
    input  S, bb_out, busy, done
  );

  modport slave (
    input  start, mode, amount, D, shift_in_right, shift_in_left,
    output S, bb_out, busy, done
  );
endinterface

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - sequential one-bit-per-clock shifter with start/busy/done
//
// Purpose: loads a WIDTH-bit operand and performs `amount` single-bit shifts,
// one per clock, in logical left, logical right, arithmetic right or rotate
// right mode.
// Optional feature macro: SHIFT_ROTATE_EN. When defined, mode 11 rotates right;
// when undefined, mode 11 behaves exactly as mode 01 (logical right).
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    slave modport of shift_seq_unit_if (start/mode/amount/D/fills in,
//          S/bb_out/busy/done out)
// All outputs come straight from registers or state decode.
module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  shift_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             bb_q, bb_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      bb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      bb_q    <= bb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    bb_d    = bb_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE so operations can run
      // back-to-back without a dead cycle.
      IDLE, DONE: begin
        if (bus.start) begin
          s_d    = bus.D;
          cnt_d  = bus.amount;
          mode_d = bus.mode;
          bb_d   = 1'b0;
          state_d = (bus.amount == '0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        // Fill bits are taken live on each step, mode comes from the latch.
        case (mode_q)
          2'b00: begin
            s_d  = {s_q[WIDTH-2:0], bus.shift_in_right};
            bb_d = s_q[WIDTH-1];
          end
          2'b10: begin
            s_d  = {s_q[WIDTH-1], s_q[WIDTH-1:1]};
            bb_d = s_q[0];
          end
`ifdef SHIFT_ROTATE_EN
          2'b11: begin
            s_d  = {s_q[0], s_q[WIDTH-1:1]};
            bb_d = s_q[0];
          end
`endif
          default: begin
            s_d  = {bus.shift_in_left, s_q[WIDTH-1:1]};
            bb_d = s_q[0];
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.S      = s_q;
  assign bus.bb_out = bb_q;
  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);

endmodule
